// File: rtl/sccb_reg_access.sv
// Register-access front end for an SCCB camera: converts one read/write request
// into the i2c master's command/data AXI-stream sequence and reports completion.
module sccb_reg_access #(
  parameter logic [6:0]  DEV_ADDR       = 7'h21,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_read,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  output logic       rsp_valid,
  output logic       busy,
  output logic [6:0] s_axis_cmd_address,
  output logic       s_axis_cmd_start,
  output logic       s_axis_cmd_read,
  output logic       s_axis_cmd_write,
  output logic       s_axis_cmd_write_multiple,
  output logic       s_axis_cmd_stop,
  output logic       s_axis_cmd_valid,
  input  logic       s_axis_cmd_ready,
  output logic [7:0] s_axis_data_tdata,
  output logic       s_axis_data_tvalid,
  input  logic       s_axis_data_tready,
  output logic       s_axis_data_tlast,
  input  logic [7:0] m_axis_data_tdata,
  input  logic       m_axis_data_tvalid,
  output logic       m_axis_data_tready,
  input  logic       m_axis_data_tlast,
  input  logic       missed_ack
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_CMD, S_W_ADDR, S_W_DATA,
    S_R_WCMD, S_R_ADDR, S_R_RCMD, S_R_DATA, S_DONE
  } state_e;

  // Everything presented to the i2c master, registered as one bundle.
  typedef struct packed {
    logic       start;
    logic       read;
    logic       write;
    logic       wmult;
    logic       stop;
    logic       cmd_valid;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       rd_ready;
  } drive_t;

  function automatic drive_t drive_for(state_e s, logic [7:0] addr, logic [7:0] data);
    drive_t d;
    d = '0;
    case (s)
      S_W_CMD, S_R_WCMD: begin
        d.start = 1'b1; d.wmult = 1'b1; d.stop = 1'b1; d.cmd_valid = 1'b1;
      end
      S_R_RCMD: begin
        d.start = 1'b1; d.read = 1'b1; d.stop = 1'b1; d.cmd_valid = 1'b1;
      end
      S_W_ADDR: begin d.tdata = addr; d.tvalid = 1'b1; end
      S_R_ADDR: begin d.tdata = addr; d.tvalid = 1'b1; d.tlast = 1'b1; end
      S_W_DATA: begin d.tdata = data; d.tvalid = 1'b1; d.tlast = 1'b1; end
      S_R_DATA: d.rd_ready = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  state_e           state_q, state_d, wait_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d, rd_q, rd_d;
  logic             read_q, read_d;
  drive_t           drv_q, drv_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             waiting, hs;
  logic             unused_tlast;

  assign unused_tlast = m_axis_data_tlast;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wait_next = S_IDLE;
    cnt_d     = '0;
    err_d     = err_q;
    addr_d    = addr_q;
    data_d    = data_q;
    read_d    = read_q;
    rd_d      = rd_q;
    waiting   = 1'b0;
    hs        = 1'b0;

    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        data_d  = req_data;
        read_d  = req_read;
        err_d   = 1'b0;
        state_d = req_read ? S_R_WCMD : S_W_CMD;
      end
      S_W_CMD:  begin waiting = 1'b1; hs = s_axis_cmd_ready;   wait_next = S_W_ADDR; end
      S_W_ADDR: begin waiting = 1'b1; hs = s_axis_data_tready; wait_next = S_W_DATA; end
      S_W_DATA: begin waiting = 1'b1; hs = s_axis_data_tready; wait_next = S_DONE;   end
      S_R_WCMD: begin waiting = 1'b1; hs = s_axis_cmd_ready;   wait_next = S_R_ADDR; end
      S_R_ADDR: begin waiting = 1'b1; hs = s_axis_data_tready; wait_next = S_R_RCMD; end
      S_R_RCMD: begin waiting = 1'b1; hs = s_axis_cmd_ready;   wait_next = S_R_DATA; end
      S_R_DATA: begin waiting = 1'b1; hs = m_axis_data_tvalid; wait_next = S_DONE;   end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A handshake in the expiry cycle wins over the timeout.
    if (waiting) begin
      if (hs) begin
        state_d = wait_next;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (state_q != S_IDLE && missed_ack) err_d = 1'b1;
    if (state_q == S_R_DATA && m_axis_data_tvalid) rd_d = m_axis_data_tdata;

    drv_d       = drive_for(state_d, addr_d, data_d);
    rsp_valid_d = (state_d == S_DONE);
    rsp_error_d = rsp_valid_d & err_d;
    rsp_data_d  = rsp_valid_d ? ((read_q && !err_d) ? rd_d : 8'h00) : rsp_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      read_q      <= 1'b0;
      rd_q        <= '0;
      drv_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      read_q      <= read_d;
      rd_q        <= rd_d;
      drv_q       <= drv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready                 = (state_q == S_IDLE);
  assign busy                      = (state_q != S_IDLE);
  assign rsp_valid                 = rsp_valid_q;
  assign rsp_error                 = rsp_error_q;
  assign rsp_data                  = rsp_data_q;
  assign s_axis_cmd_address        = DEV_ADDR;
  assign s_axis_cmd_start          = drv_q.start;
  assign s_axis_cmd_read           = drv_q.read;
  assign s_axis_cmd_write          = drv_q.write;
  assign s_axis_cmd_write_multiple = drv_q.wmult;
  assign s_axis_cmd_stop           = drv_q.stop;
  assign s_axis_cmd_valid          = drv_q.cmd_valid;
  assign s_axis_data_tdata         = drv_q.tdata;
  assign s_axis_data_tvalid        = drv_q.tvalid;
  assign s_axis_data_tlast         = drv_q.tlast;
  assign m_axis_data_tready        = drv_q.rd_ready;

endmodule
